// File: rtl/riscv_pkg.sv
// Shared types and constants for the five-stage RV32I core.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    typedef enum logic [1:0] {
        ResultAlu = 2'b00,
        ResultMem = 2'b01,
        ResultPc4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_ctrl_e;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic [2:0] ALUControl;
        logic       ALUSrc;
    } ctrl_e_t;

    localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// One pipeline field: reset to zero, flush to FlushVal, hold on stall, else capture.
module pipe_field_reg #(
    parameter int unsigned       Width    = 1,
    parameter logic [Width-1:0] FlushVal = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] field_d;
    logic [Width-1:0] field_q;

    // Flush beats stall so a bubble is never lost behind a held instruction.
    always_comb begin
        field_d = field_q;
        if (flush_i) begin
            field_d = FlushVal;
        end else if (!stall_i) begin
            field_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            field_q <= '0;
        end else begin
            field_q <= field_d;
        end
    end

    assign q_o = field_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-Execute pipeline register with stall, flush and a valid bit.
module id_ex_pipe_reg
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN,
    parameter int unsigned REGW = riscv_pkg::REGW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            Valid_D,
    input  logic            RegWrite_D,
    input  logic            MemWrite_D,
    input  logic            Jump_D,
    input  logic            Branch_D,
    input  logic            ALUSrc_D,
    input  logic [1:0]      ResultSrc_D,
    input  logic [2:0]      ALUControl_D,
    input  logic [XLEN-1:0] RD1_D,
    input  logic [XLEN-1:0] RD2_D,
    input  logic [XLEN-1:0] PC_D,
    input  logic [XLEN-1:0] ImmExt_D,
    input  logic [XLEN-1:0] PCPlus4_D,
    input  logic [REGW-1:0] Rs1_D,
    input  logic [REGW-1:0] Rs2_D,
    input  logic [REGW-1:0] Rd_D,
    output logic            Valid_E,
    output logic            RegWrite_E,
    output logic            MemWrite_E,
    output logic            Jump_E,
    output logic            Branch_E,
    output logic            ALUSrc_E,
    output logic [1:0]      ResultSrc_E,
    output logic [2:0]      ALUControl_E,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] PC_E,
    output logic [XLEN-1:0] ImmExt_E,
    output logic [XLEN-1:0] PCPlus4_E,
    output logic [REGW-1:0] Rs1_E,
    output logic [REGW-1:0] Rs2_E,
    output logic [REGW-1:0] Rd_E
);

    localparam int unsigned CtrlW = $bits(ctrl_e_t);
    localparam int unsigned DataW = 5 * XLEN;
    localparam int unsigned IdxW  = 3 * REGW;

    ctrl_e_t          ctrl_d, ctrl_q;
    logic [DataW-1:0] data_d, data_q;
    logic [IdxW-1:0]  idx_d,  idx_q;

    always_comb begin
        ctrl_d            = CTRL_BUBBLE;
        ctrl_d.RegWrite   = RegWrite_D;
        ctrl_d.ResultSrc  = ResultSrc_D;
        ctrl_d.MemWrite   = MemWrite_D;
        ctrl_d.Jump       = Jump_D;
        ctrl_d.Branch     = Branch_D;
        ctrl_d.ALUControl = ALUControl_D;
        ctrl_d.ALUSrc     = ALUSrc_D;
    end

    assign data_d = {RD1_D, RD2_D, PC_D, ImmExt_D, PCPlus4_D};
    // Zeroed indices on flush keep the forwarding comparators from matching a live register.
    assign idx_d  = {Rs1_D, Rs2_D, Rd_D};

    pipe_field_reg #(
        .Width    (CtrlW),
        .FlushVal (CTRL_BUBBLE)
    ) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .stall_i (StallE),
        .flush_i (FlushE),
        .d_i     (ctrl_d),
        .q_o     (ctrl_q)
    );

    pipe_field_reg #(
        .Width    (DataW),
        .FlushVal ('0)
    ) u_data (
        .clk     (clk),
        .reset   (reset),
        .stall_i (StallE),
        .flush_i (FlushE),
        .d_i     (data_d),
        .q_o     (data_q)
    );

    pipe_field_reg #(
        .Width    (IdxW),
        .FlushVal ('0)
    ) u_idx (
        .clk     (clk),
        .reset   (reset),
        .stall_i (StallE),
        .flush_i (FlushE),
        .d_i     (idx_d),
        .q_o     (idx_q)
    );

    pipe_field_reg #(
        .Width    (1),
        .FlushVal (1'b0)
    ) u_valid (
        .clk     (clk),
        .reset   (reset),
        .stall_i (StallE),
        .flush_i (FlushE),
        .d_i     (Valid_D),
        .q_o     (Valid_E)
    );

    assign RegWrite_E   = ctrl_q.RegWrite;
    assign ResultSrc_E  = ctrl_q.ResultSrc;
    assign MemWrite_E   = ctrl_q.MemWrite;
    assign Jump_E       = ctrl_q.Jump;
    assign Branch_E     = ctrl_q.Branch;
    assign ALUControl_E = ctrl_q.ALUControl;
    assign ALUSrc_E     = ctrl_q.ALUSrc;

    assign {RD1_E, RD2_E, PC_E, ImmExt_E, PCPlus4_E} = data_q;
    assign {Rs1_E, Rs2_E, Rd_E}                      = idx_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: reset, capture, stall, flush and their collisions.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, StallE, FlushE, Valid_D;
    logic        RegWrite_D, MemWrite_D, Jump_D, Branch_D, ALUSrc_D;
    logic [1:0]  ResultSrc_D;
    logic [2:0]  ALUControl_D;
    logic [31:0] RD1_D, RD2_D, PC_D, ImmExt_D, PCPlus4_D;
    logic [4:0]  Rs1_D, Rs2_D, Rd_D;

    logic        Valid_E, RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E;
    logic [1:0]  ResultSrc_E;
    logic [2:0]  ALUControl_E;
    logic [31:0] RD1_E, RD2_E, PC_E, ImmExt_E, PCPlus4_E;
    logic [4:0]  Rs1_E, Rs2_E, Rd_E;

    int errors = 0;
    int checks = 0;

    // 1+1+1+1+1+1+2+3+5*32+3*5 = 186 bits
    logic [185:0] all_e;
    assign all_e = {Valid_E, RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E, ResultSrc_E,
                    ALUControl_E, RD1_E, RD2_E, PC_E, ImmExt_E, PCPlus4_E, Rs1_E, Rs2_E, Rd_E};

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk          (clk),
        .reset        (reset),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .Valid_D      (Valid_D),
        .RegWrite_D   (RegWrite_D),
        .MemWrite_D   (MemWrite_D),
        .Jump_D       (Jump_D),
        .Branch_D     (Branch_D),
        .ALUSrc_D     (ALUSrc_D),
        .ResultSrc_D  (ResultSrc_D),
        .ALUControl_D (ALUControl_D),
        .RD1_D        (RD1_D),
        .RD2_D        (RD2_D),
        .PC_D         (PC_D),
        .ImmExt_D     (ImmExt_D),
        .PCPlus4_D    (PCPlus4_D),
        .Rs1_D        (Rs1_D),
        .Rs2_D        (Rs2_D),
        .Rd_D         (Rd_D),
        .Valid_E      (Valid_E),
        .RegWrite_E   (RegWrite_E),
        .MemWrite_E   (MemWrite_E),
        .Jump_E       (Jump_E),
        .Branch_E     (Branch_E),
        .ALUSrc_E     (ALUSrc_E),
        .ResultSrc_E  (ResultSrc_E),
        .ALUControl_E (ALUControl_E),
        .RD1_E        (RD1_E),
        .RD2_E        (RD2_E),
        .PC_E         (PC_E),
        .ImmExt_E     (ImmExt_E),
        .PCPlus4_E    (PCPlus4_E),
        .Rs1_E        (Rs1_E),
        .Rs2_E        (Rs2_E),
        .Rd_E         (Rd_E)
    );

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_zero();
        Valid_D = 0; RegWrite_D = 0; MemWrite_D = 0; Jump_D = 0; Branch_D = 0; ALUSrc_D = 0;
        ResultSrc_D = 0; ALUControl_D = 0;
        RD1_D = 0; RD2_D = 0; PC_D = 0; ImmExt_D = 0; PCPlus4_D = 0;
        Rs1_D = 0; Rs2_D = 0; Rd_D = 0;
    endtask

    task automatic test_reset();
        reset = 1; StallE = 0; FlushE = 0;
        Valid_D = 1; RegWrite_D = 1; MemWrite_D = 1; Jump_D = 1; Branch_D = 1; ALUSrc_D = 1;
        ResultSrc_D = 2'b11; ALUControl_D = 3'b111;
        RD1_D = '1; RD2_D = '1; PC_D = '1; ImmExt_D = '1; PCPlus4_D = '1;
        Rs1_D = '1; Rs2_D = '1; Rd_D = '1;
        step();
        step();
        checks++;
        if (all_e !== '0) begin
            errors++;
            $display("FAIL reset_all: got %h want 0", all_e);
        end
        checks++;
        if (Valid_E !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", Valid_E);
        end
        reset = 0;
        drive_zero();
        step();
    endtask

    task automatic test_capture();
        RD2_D = 32'hDEADBEEF; Rd_D = 5'd5; RegWrite_D = 1; Valid_D = 1;
        #1;
        checks++;
        if (RD2_E !== 32'h0 || Valid_E !== 1'b0) begin
            errors++;
            $display("FAIL capture_early: got RD2_E=%h Valid_E=%b want 0/0", RD2_E, Valid_E);
        end
        step();
        checks++;
        if ({RD2_E, Rd_E, RegWrite_E, Valid_E} !== {32'hDEADBEEF, 5'd5, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL capture: got RD2_E=%h Rd_E=%0d RegWrite_E=%b Valid_E=%b want deadbeef/5/1/1",
                     RD2_E, Rd_E, RegWrite_E, Valid_E);
        end
    endtask

    task automatic test_all_fields();
        Valid_D = 0; RegWrite_D = 0; MemWrite_D = 1; Jump_D = 1; Branch_D = 0; ALUSrc_D = 1;
        ResultSrc_D = 2'b10; ALUControl_D = 3'b101;
        RD1_D = 32'h11111111; RD2_D = 32'h22222222; PC_D = 32'h00000400;
        ImmExt_D = 32'hFFFFF800; PCPlus4_D = 32'h00000404;
        Rs1_D = 5'd31; Rs2_D = 5'd17; Rd_D = 5'd9;
        step();
        checks++;
        if (all_e !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 3'b101,
                       32'h11111111, 32'h22222222, 32'h00000400, 32'hFFFFF800, 32'h00000404,
                       5'd31, 5'd17, 5'd9}) begin
            errors++;
            $display("FAIL all_fields_invalid_capture: got %h", all_e);
        end
    endtask

    task automatic test_stall();
        drive_zero();
        PC_D = 32'h100; Valid_D = 1;
        step();
        checks++;
        if (PC_E !== 32'h100) begin
            errors++;
            $display("FAIL stall_load: got %h want 100", PC_E);
        end
        StallE = 1;
        for (int i = 1; i <= 3; i++) begin
            PC_D = 32'h100 + 32'(4 * i);
            step();
            checks++;
            if (PC_E !== 32'h100) begin
                errors++;
                $display("FAIL stall_hold%0d: got %h want 100", i, PC_E);
            end
        end
        StallE = 0;
        step();
        checks++;
        if (PC_E !== 32'h10C) begin
            errors++;
            $display("FAIL stall_release: got %h want 10c", PC_E);
        end
    endtask

    task automatic test_flush();
        drive_zero();
        MemWrite_D = 1; Rs2_D = 5'd7; Rd_D = 5'd3; RD1_D = 32'h1234; Valid_D = 1;
        step();
        checks++;
        if ({MemWrite_E, Rs2_E, Rd_E, RD1_E} !== {1'b1, 5'd7, 5'd3, 32'h1234}) begin
            errors++;
            $display("FAIL flush_pre: got MemWrite_E=%b Rs2_E=%0d Rd_E=%0d RD1_E=%h want 1/7/3/1234",
                     MemWrite_E, Rs2_E, Rd_E, RD1_E);
        end
        FlushE = 1;
        step();
        FlushE = 0;
        checks++;
        if (all_e !== '0) begin
            errors++;
            $display("FAIL flush_bubble: got %h want 0", all_e);
        end
        // A held bubble must stay a bubble despite live inputs.
        StallE = 1;
        step();
        StallE = 0;
        checks++;
        if (all_e !== '0) begin
            errors++;
            $display("FAIL flush_bubble_held: got %h want 0", all_e);
        end
    endtask

    task automatic test_flush_stall();
        drive_zero();
        RegWrite_D = 1; Valid_D = 1; PC_D = 32'h200;
        step();
        checks++;
        if ({Valid_E, RegWrite_E, PC_E} !== {1'b1, 1'b1, 32'h200}) begin
            errors++;
            $display("FAIL collision_pre: got %b%b %h want 11 200", Valid_E, RegWrite_E, PC_E);
        end
        StallE = 1; FlushE = 1;
        step();
        StallE = 0; FlushE = 0;
        checks++;
        if ({Valid_E, RegWrite_E, PC_E} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL collision: got Valid_E=%b RegWrite_E=%b PC_E=%h want 0/0/0",
                     Valid_E, RegWrite_E, PC_E);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive_zero();
        RD1_D = 32'h55; Valid_D = 1;
        step();
        StallE = 1; RD1_D = 32'h66;
        step();
        checks++;
        if (RD1_E !== 32'h55) begin
            errors++;
            $display("FAIL rst_stall_hold: got %h want 55", RD1_E);
        end
        reset = 1;
        step();
        checks++;
        if (RD1_E !== 32'h0 || Valid_E !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall_clear: got RD1_E=%h Valid_E=%b want 0/0", RD1_E, Valid_E);
        end
        reset = 0; StallE = 0; RD1_D = 32'hAA;
        step();
        checks++;
        if (RD1_E !== 32'hAA) begin
            errors++;
            $display("FAIL rst_release: got %h want aa", RD1_E);
        end
    endtask

    task automatic test_back_to_back();
        drive_zero();
        Valid_D = 1;
        for (int i = 0; i < 4; i++) begin
            PC_D = 32'h1000 + 32'(4 * i);
            Rd_D = 5'(i + 1);
            step();
            checks++;
            if ({PC_E, Rd_E} !== {32'h1000 + 32'(4 * i), 5'(i + 1)}) begin
                errors++;
                $display("FAIL b2b%0d: got PC_E=%h Rd_E=%0d want %h/%0d",
                         i, PC_E, Rd_E, 32'h1000 + 32'(4 * i), i + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_all_fields();
        test_stall();
        test_flush();
        test_flush_stall();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
